// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared constants for the register-file read scheduler:
//                bank/row/collector-ID widths, bank FIFO depth, the width of
//                the per-bank credit counters and the per-bank cost encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int NUM_BANK   = 4;
    localparam int BANK_W     = 2;
    localparam int ROW_W      = 3;
    localparam int OCID_W     = 3;
    localparam int FIFO_DEPTH = 8;

    // One extra bit so the counter can hold FIFO_DEPTH itself.
    localparam int CREDIT_W   = $clog2(FIFO_DEPTH) + 1;

    // Credits a single request consumes in one bank.
    localparam int                COST_W    = 2;
    localparam logic [COST_W-1:0] COST_NONE = 2'd0;
    localparam logic [COST_W-1:0] COST_ONE  = 2'd1;
    localparam logic [COST_W-1:0] COST_TWO  = 2'd2;

    // Cost in one bank from "source 1 lands here" and "source 2 lands here and
    // is not merged into source 1's entry".
    function automatic logic [COST_W-1:0] bank_cost(input logic hit1, input logic hit2);
        logic [COST_W-1:0] cost;
        if (hit1 && hit2) begin
            cost = COST_TWO;
        end else if (hit1 || hit2) begin
            cost = COST_ONE;
        end else begin
            cost = COST_NONE;
        end
        return cost;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_read_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : N-wide round-robin arbiter. Grants the first eligible
//                requester found when scanning upward from i_ptr (wrapping).
//                Purely combinational; the caller owns the pointer register.
//  Ports       : i_eligible - per-requester eligibility
//                i_ptr      - index with highest priority this cycle
//                o_grant    - one-hot grant, zero when nothing is eligible
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_eligible,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant
);

    logic w_found;

    // Outer loop walks priority order (distance from the pointer), inner loop
    // finds the requester at that distance; the first hit wins.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int off = 0; off < N; off++) begin
            for (int j = 0; j < N; j++) begin
                if (!w_found && i_eligible[j] && (((int'(i_ptr) + off) % N) == j)) begin
                    o_grant[j] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_read_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : rf_read_scheduler
//  Description : Arbitrates operand-read requests from NUM_OC operand
//                collectors into the per-bank register-file request FIFOs.
//                Per-bank credit counters keep every FIFO from overflowing;
//                two sources hitting the same bank row collapse into one
//                "same" entry.
//  Ports       : oc_*        - collector requests (flattened per collector)
//                oc_grant    - combinational one-hot grant
//                bank_pop    - FIFO dequeue strobes, one credit back each
//                bank_*      - registered push strobes and entry fields,
//                              valid for the cycle after the grant
//                credit_err  - sticky pop-while-full indication
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_read_scheduler
    import rf_pkg::*;
#(
    parameter int NUM_OC = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_OC-1:0]          oc_req_valid,
    input  logic [NUM_OC-1:0]          oc_src1_valid,
    input  logic [NUM_OC-1:0]          oc_src2_valid,
    input  logic [NUM_OC*BANK_W-1:0]   oc_src1_bank,
    input  logic [NUM_OC*ROW_W-1:0]    oc_src1_row,
    input  logic [NUM_OC*BANK_W-1:0]   oc_src2_bank,
    input  logic [NUM_OC*ROW_W-1:0]    oc_src2_row,
    output logic [NUM_OC-1:0]          oc_grant,
    input  logic [NUM_BANK-1:0]        bank_pop,
    output logic [NUM_BANK-1:0]        bank_push,
    output logic [NUM_BANK-1:0]        bank_push2,
    output logic [NUM_BANK-1:0]        bank_same,
    output logic [NUM_BANK*ROW_W-1:0]  bank_row_a,
    output logic [NUM_BANK*ROW_W-1:0]  bank_row_b,
    output logic [NUM_BANK*OCID_W-1:0] bank_ocid,
    output logic                       credit_err
);

    localparam int                  c_PTR_W = (NUM_OC > 1) ? $clog2(NUM_OC) : 1;
    localparam logic [CREDIT_W-1:0] c_FULL  = CREDIT_W'(FIFO_DEPTH);

    logic [BANK_W-1:0]   w_s1_bank [NUM_OC];
    logic [BANK_W-1:0]   w_s2_bank [NUM_OC];
    logic [ROW_W-1:0]    w_s1_row  [NUM_OC];
    logic [ROW_W-1:0]    w_s2_row  [NUM_OC];
    logic [NUM_OC-1:0]   w_same_row;
    logic [NUM_BANK-1:0] w_hit1    [NUM_OC];
    logic [NUM_BANK-1:0] w_hit2    [NUM_OC];
    logic [COST_W-1:0]   w_cost    [NUM_OC][NUM_BANK];
    logic [NUM_OC-1:0]   w_elig;
    logic [NUM_OC-1:0]   w_arb_grant;
    logic [NUM_OC-1:0]   w_grant;
    logic                w_any;
    logic [c_PTR_W-1:0]  w_gidx;
    logic [COST_W-1:0]   w_debit   [NUM_BANK];

    logic [CREDIT_W-1:0]        r_credit [NUM_BANK];
    logic [c_PTR_W-1:0]         r_ptr;
    logic [NUM_BANK-1:0]        r_push;
    logic [NUM_BANK-1:0]        r_push2;
    logic [NUM_BANK-1:0]        r_same;
    logic [NUM_BANK*ROW_W-1:0]  r_row_a;
    logic [NUM_BANK*ROW_W-1:0]  r_row_b;
    logic [NUM_BANK*OCID_W-1:0] r_ocid;
    logic                       r_credit_err;

    // Unpack the flattened request fields and detect same-bank/same-row pairs.
    always_comb begin
        for (int i = 0; i < NUM_OC; i++) begin
            w_s1_bank[i]  = oc_src1_bank[i*BANK_W +: BANK_W];
            w_s2_bank[i]  = oc_src2_bank[i*BANK_W +: BANK_W];
            w_s1_row[i]   = oc_src1_row[i*ROW_W +: ROW_W];
            w_s2_row[i]   = oc_src2_row[i*ROW_W +: ROW_W];
            w_same_row[i] = oc_src1_valid[i] && oc_src2_valid[i] &&
                            (w_s1_bank[i] == w_s2_bank[i]) &&
                            (w_s1_row[i] == w_s2_row[i]);
        end
    end

    // Per-bank cost of each collector's request. A merged source 2 is folded
    // into source 1's entry, so it never costs a credit of its own.
    always_comb begin
        for (int i = 0; i < NUM_OC; i++) begin
            w_hit1[i] = '0;
            w_hit2[i] = '0;
            for (int b = 0; b < NUM_BANK; b++) begin
                w_hit1[i][b] = oc_src1_valid[i] && (w_s1_bank[i] == BANK_W'(b));
                w_hit2[i][b] = oc_src2_valid[i] && (w_s2_bank[i] == BANK_W'(b)) && !w_same_row[i];
                w_cost[i][b] = bank_cost(w_hit1[i][b], w_hit2[i][b]);
            end
        end
    end

    // Eligibility uses only the registered credits; same-cycle pops are not
    // forwarded so the check stays off the pop path.
    always_comb begin
        for (int i = 0; i < NUM_OC; i++) begin
            w_elig[i] = oc_req_valid[i];
            for (int b = 0; b < NUM_BANK; b++) begin
                if ({{(CREDIT_W-COST_W){1'b0}}, w_cost[i][b]} > r_credit[b]) begin
                    w_elig[i] = 1'b0;
                end
            end
        end
    end

    rr_arbiter #(
        .N     (NUM_OC),
        .PTR_W (c_PTR_W)
    ) u_rr_arbiter (
        .i_eligible (w_elig),
        .i_ptr      (r_ptr),
        .o_grant    (w_arb_grant)
    );

    always_comb begin
        w_grant = rst ? '0 : w_arb_grant;
        w_any   = |w_grant;
        w_gidx  = '0;
        for (int i = 0; i < NUM_OC; i++) begin
            if (w_grant[i]) begin
                w_gidx = c_PTR_W'(i);
            end
        end
        for (int b = 0; b < NUM_BANK; b++) begin
            w_debit[b] = w_any ? w_cost[w_gidx][b] : COST_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                r_credit[b] <= c_FULL;
            end
            r_ptr        <= '0;
            r_push       <= '0;
            r_push2      <= '0;
            r_same       <= '0;
            r_row_a      <= '0;
            r_row_b      <= '0;
            r_ocid       <= '0;
            r_credit_err <= 1'b0;
        end else begin
            if (w_any) begin
                r_ptr <= (w_gidx == c_PTR_W'(NUM_OC - 1)) ? '0 : w_gidx + 1'b1;
            end
            for (int b = 0; b < NUM_BANK; b++) begin
                r_push[b]  <= w_debit[b] != COST_NONE;
                r_push2[b] <= w_debit[b] == COST_TWO;
                r_same[b]  <= w_any && w_same_row[w_gidx] && w_hit1[w_gidx][b];
                // Entry A is source 1 whenever source 1 targets this bank,
                // otherwise it carries source 2. Entry B only ever holds
                // source 2. Fields of untouched banks keep their old values.
                if (w_debit[b] != COST_NONE) begin
                    r_row_a[b*ROW_W +: ROW_W]   <= w_hit1[w_gidx][b] ? w_s1_row[w_gidx] : w_s2_row[w_gidx];
                    r_row_b[b*ROW_W +: ROW_W]   <= w_s2_row[w_gidx];
                    r_ocid[b*OCID_W +: OCID_W]  <= OCID_W'(w_gidx);
                end
                // A pop against a full counter with nothing debited would
                // overflow: hold at full and flag it.
                if (bank_pop[b] && (r_credit[b] == c_FULL) && (w_debit[b] == COST_NONE)) begin
                    r_credit_err <= 1'b1;
                end else begin
                    r_credit[b] <= r_credit[b]
                                 - {{(CREDIT_W-COST_W){1'b0}}, w_debit[b]}
                                 + {{(CREDIT_W-1){1'b0}}, bank_pop[b]};
                end
            end
        end
    end

    assign oc_grant   = w_grant;
    assign bank_push  = r_push;
    assign bank_push2 = r_push2;
    assign bank_same  = r_same;
    assign bank_row_a = r_row_a;
    assign bank_row_b = r_row_b;
    assign bank_ocid  = r_ocid;
    assign credit_err = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_rf_read_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_read_scheduler
//  Description : Directed self-checking bench for rf_read_scheduler. Inputs
//                change on the falling edge; the combinational grant and the
//                registered bank outputs are sampled 1ns later.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rf_read_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  oc_req_valid, oc_src1_valid, oc_src2_valid;
    logic [7:0]  oc_src1_bank, oc_src2_bank;
    logic [11:0] oc_src1_row, oc_src2_row;
    logic [3:0]  oc_grant, bank_pop, bank_push, bank_push2, bank_same;
    logic [11:0] bank_row_a, bank_row_b, bank_ocid;
    logic        credit_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_read_scheduler #(.NUM_OC(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .oc_req_valid  (oc_req_valid),
        .oc_src1_valid (oc_src1_valid),
        .oc_src2_valid (oc_src2_valid),
        .oc_src1_bank  (oc_src1_bank),
        .oc_src1_row   (oc_src1_row),
        .oc_src2_bank  (oc_src2_bank),
        .oc_src2_row   (oc_src2_row),
        .oc_grant      (oc_grant),
        .bank_pop      (bank_pop),
        .bank_push     (bank_push),
        .bank_push2    (bank_push2),
        .bank_same     (bank_same),
        .bank_row_a    (bank_row_a),
        .bank_row_b    (bank_row_b),
        .bank_ocid     (bank_ocid),
        .credit_err    (credit_err)
    );

    task automatic clear_req();
        oc_req_valid  = '0;
        oc_src1_valid = '0;
        oc_src2_valid = '0;
        oc_src1_bank  = '0;
        oc_src2_bank  = '0;
        oc_src1_row   = '0;
        oc_src2_row   = '0;
    endtask

    task automatic set_req(input int oc, input int s1v, input int s1b, input int s1r,
                           input int s2v, input int s2b, input int s2r);
        oc_req_valid[oc]         = 1'b1;
        oc_src1_valid[oc]        = s1v[0];
        oc_src2_valid[oc]        = s2v[0];
        oc_src1_bank[oc*2 +: 2]  = s1b[1:0];
        oc_src2_bank[oc*2 +: 2]  = s2b[1:0];
        oc_src1_row[oc*3 +: 3]   = s1r[2:0];
        oc_src2_row[oc*3 +: 3]   = s2r[2:0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bank_pop = '0;
        clear_req();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bank_pop = '0;
        clear_req();
        set_req(0, 1, 1, 5, 0, 0, 0);
        #1;
        n_cmp++; if (oc_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", oc_grant); end
        @(negedge clk);
        rst = 1'b0;
        clear_req();
        #1;
        n_cmp++; if (bank_push !== 4'b0000) begin n_fail++; $display("FAIL reset_push: got %b expected 0000", bank_push); end
        n_cmp++; if (bank_push2 !== 4'b0000) begin n_fail++; $display("FAIL reset_push2: got %b expected 0000", bank_push2); end
        n_cmp++; if (bank_same !== 4'b0000) begin n_fail++; $display("FAIL reset_same: got %b expected 0000", bank_same); end
        n_cmp++; if (bank_row_a !== 12'h000) begin n_fail++; $display("FAIL reset_row_a: got %h expected 000", bank_row_a); end
        n_cmp++; if (bank_row_b !== 12'h000) begin n_fail++; $display("FAIL reset_row_b: got %h expected 000", bank_row_b); end
        n_cmp++; if (bank_ocid !== 12'h000) begin n_fail++; $display("FAIL reset_ocid: got %h expected 000", bank_ocid); end
        n_cmp++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", credit_err); end
        for (int b = 0; b < 4; b++) begin
            n_cmp++; if (dut.r_credit[b[1:0]] !== 4'd8) begin n_fail++; $display("FAIL reset_credit%0d: got %0d expected 8", b, dut.r_credit[b[1:0]]); end
        end
    endtask

    // OC0 reads bank1 row5 only.
    task automatic test_single();
        @(negedge clk);
        set_req(0, 1, 1, 5, 0, 0, 0);
        #1;
        n_cmp++; if (oc_grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", oc_grant); end
        @(negedge clk);
        clear_req();
        #1;
        n_cmp++; if (bank_push !== 4'b0010) begin n_fail++; $display("FAIL single_push: got %b expected 0010", bank_push); end
        n_cmp++; if (bank_push2 !== 4'b0000) begin n_fail++; $display("FAIL single_push2: got %b expected 0000", bank_push2); end
        n_cmp++; if (bank_row_a[5:3] !== 3'd5) begin n_fail++; $display("FAIL single_row_a: got %0d expected 5", bank_row_a[5:3]); end
        n_cmp++; if (bank_ocid[5:3] !== 3'd0) begin n_fail++; $display("FAIL single_ocid: got %0d expected 0", bank_ocid[5:3]); end
        n_cmp++; if (dut.r_credit[1] !== 4'd7) begin n_fail++; $display("FAIL single_credit: got %0d expected 7", dut.r_credit[1]); end
        @(negedge clk);
        #1;
        n_cmp++; if (bank_push !== 4'b0000) begin n_fail++; $display("FAIL single_push_idle: got %b expected 0000", bank_push); end
        n_cmp++; if (bank_row_a[5:3] !== 3'd5) begin n_fail++; $display("FAIL single_row_hold: got %0d expected 5", bank_row_a[5:3]); end
    endtask

    // OC2: both sources bank3 row2 -> one merged entry.
    task automatic test_same();
        @(negedge clk);
        set_req(2, 1, 3, 2, 1, 3, 2);
        #1;
        n_cmp++; if (oc_grant !== 4'b0100) begin n_fail++; $display("FAIL same_grant: got %b expected 0100", oc_grant); end
        @(negedge clk);
        clear_req();
        #1;
        n_cmp++; if (bank_push !== 4'b1000) begin n_fail++; $display("FAIL same_push: got %b expected 1000", bank_push); end
        n_cmp++; if (bank_same !== 4'b1000) begin n_fail++; $display("FAIL same_same: got %b expected 1000", bank_same); end
        n_cmp++; if (bank_push2 !== 4'b0000) begin n_fail++; $display("FAIL same_push2: got %b expected 0000", bank_push2); end
        n_cmp++; if (bank_row_a[11:9] !== 3'd2) begin n_fail++; $display("FAIL same_row_a: got %0d expected 2", bank_row_a[11:9]); end
        n_cmp++; if (bank_ocid[11:9] !== 3'd2) begin n_fail++; $display("FAIL same_ocid: got %0d expected 2", bank_ocid[11:9]); end
        n_cmp++; if (dut.r_credit[3] !== 4'd7) begin n_fail++; $display("FAIL same_credit: got %0d expected 7", dut.r_credit[3]); end
    endtask

    // OC1: bank0 row1 and bank0 row4 -> two entries, two credits.
    task automatic test_two_op();
        @(negedge clk);
        set_req(1, 1, 0, 1, 1, 0, 4);
        #1;
        n_cmp++; if (oc_grant !== 4'b0010) begin n_fail++; $display("FAIL twoop_grant: got %b expected 0010", oc_grant); end
        @(negedge clk);
        clear_req();
        #1;
        n_cmp++; if (bank_push !== 4'b0001) begin n_fail++; $display("FAIL twoop_push: got %b expected 0001", bank_push); end
        n_cmp++; if (bank_push2 !== 4'b0001) begin n_fail++; $display("FAIL twoop_push2: got %b expected 0001", bank_push2); end
        n_cmp++; if (bank_same !== 4'b0000) begin n_fail++; $display("FAIL twoop_same: got %b expected 0000", bank_same); end
        n_cmp++; if (bank_row_a[2:0] !== 3'd1) begin n_fail++; $display("FAIL twoop_row_a: got %0d expected 1", bank_row_a[2:0]); end
        n_cmp++; if (bank_row_b[2:0] !== 3'd4) begin n_fail++; $display("FAIL twoop_row_b: got %0d expected 4", bank_row_b[2:0]); end
        n_cmp++; if (bank_ocid[2:0] !== 3'd1) begin n_fail++; $display("FAIL twoop_ocid: got %0d expected 1", bank_ocid[2:0]); end
        n_cmp++; if (dut.r_credit[0] !== 4'd6) begin n_fail++; $display("FAIL twoop_credit: got %0d expected 6", dut.r_credit[0]); end
    endtask

    // OC0: src1 bank2 row3, src2 bank1 row6 -> one entry in each bank.
    task automatic test_split();
        @(negedge clk);
        set_req(0, 1, 2, 3, 1, 1, 6);
        #1;
        n_cmp++; if (oc_grant !== 4'b0001) begin n_fail++; $display("FAIL split_grant: got %b expected 0001", oc_grant); end
        @(negedge clk);
        clear_req();
        #1;
        n_cmp++; if (bank_push !== 4'b0110) begin n_fail++; $display("FAIL split_push: got %b expected 0110", bank_push); end
        n_cmp++; if (bank_push2 !== 4'b0000) begin n_fail++; $display("FAIL split_push2: got %b expected 0000", bank_push2); end
        n_cmp++; if (bank_row_a[8:6] !== 3'd3) begin n_fail++; $display("FAIL split_row_a2: got %0d expected 3", bank_row_a[8:6]); end
        n_cmp++; if (bank_row_a[5:3] !== 3'd6) begin n_fail++; $display("FAIL split_row_a1: got %0d expected 6", bank_row_a[5:3]); end
        n_cmp++; if (dut.r_credit[1] !== 4'd6) begin n_fail++; $display("FAIL split_credit1: got %0d expected 6", dut.r_credit[1]); end
        n_cmp++; if (dut.r_credit[2] !== 4'd7) begin n_fail++; $display("FAIL split_credit2: got %0d expected 7", dut.r_credit[2]); end
    endtask

    // OC3 with no valid source: granted, no push, credits untouched.
    task automatic test_zero_cost();
        @(negedge clk);
        set_req(3, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (oc_grant !== 4'b1000) begin n_fail++; $display("FAIL zero_grant: got %b expected 1000", oc_grant); end
        @(negedge clk);
        clear_req();
        #1;
        n_cmp++; if (bank_push !== 4'b0000) begin n_fail++; $display("FAIL zero_push: got %b expected 0000", bank_push); end
        n_cmp++; if (dut.r_credit[0] !== 4'd6) begin n_fail++; $display("FAIL zero_credit0: got %0d expected 6", dut.r_credit[0]); end
        n_cmp++; if (dut.r_credit[3] !== 4'd7) begin n_fail++; $display("FAIL zero_credit3: got %0d expected 7", dut.r_credit[3]); end
    endtask

    // All four collectors request continuously, OCi -> bank i row i.
    task automatic test_rotation();
        int pb;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1, i, i, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_cmp++; if (oc_grant !== (4'b0001 << (k % 4))) begin n_fail++; $display("FAIL rot_grant%0d: got %b expected %b", k, oc_grant, 4'b0001 << (k % 4)); end
            if (k > 0) begin
                pb = (k - 1) % 4;
                n_cmp++; if (bank_push !== (4'b0001 << pb)) begin n_fail++; $display("FAIL rot_push%0d: got %b expected %b", k, bank_push, 4'b0001 << pb); end
                n_cmp++; if (bank_ocid[pb*3 +: 3] !== pb[2:0]) begin n_fail++; $display("FAIL rot_ocid%0d: got %0d expected %0d", k, bank_ocid[pb*3 +: 3], pb); end
            end
        end
        @(negedge clk);
        clear_req();
        #1;
        n_cmp++; if (bank_push !== 4'b0001) begin n_fail++; $display("FAIL rot_push_last: got %b expected 0001", bank_push); end
        n_cmp++; if (dut.r_credit[0] !== 4'd6) begin n_fail++; $display("FAIL rot_credit0: got %0d expected 6", dut.r_credit[0]); end
        n_cmp++; if (dut.r_credit[3] !== 4'd7) begin n_fail++; $display("FAIL rot_credit3: got %0d expected 7", dut.r_credit[3]); end
    endtask

    // Drain bank2's credit, then return credits with pops.
    task automatic test_fill();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            set_req(2, 1, 2, k, 0, 0, 0);
            #1;
            n_cmp++; if (oc_grant !== 4'b0100) begin n_fail++; $display("FAIL fill_grant%0d: got %b expected 0100", k, oc_grant); end
            n_cmp++; if (dut.r_credit[2] !== 4'(8 - k)) begin n_fail++; $display("FAIL fill_credit%0d: got %0d expected %0d", k, dut.r_credit[2], 8 - k); end
        end
        @(negedge clk);
        #1;
        n_cmp++; if (oc_grant !== 4'b0000) begin n_fail++; $display("FAIL full_grant: got %b expected 0000", oc_grant); end
        n_cmp++; if (dut.r_credit[2] !== 4'd0) begin n_fail++; $display("FAIL full_credit: got %0d expected 0", dut.r_credit[2]); end
        bank_pop = 4'b0100;
        #1;
        n_cmp++; if (oc_grant !== 4'b0000) begin n_fail++; $display("FAIL pop_same_cycle_grant: got %b expected 0000", oc_grant); end
        @(negedge clk);
        bank_pop = 4'b0000;
        #1;
        n_cmp++; if (oc_grant !== 4'b0100) begin n_fail++; $display("FAIL pop_next_grant: got %b expected 0100", oc_grant); end
        n_cmp++; if (dut.r_credit[2] !== 4'd1) begin n_fail++; $display("FAIL pop_credit: got %0d expected 1", dut.r_credit[2]); end
        @(negedge clk);
        clear_req();
        bank_pop = 4'b0100;
        #1;
        n_cmp++; if (dut.r_credit[2] !== 4'd0) begin n_fail++; $display("FAIL refill_credit: got %0d expected 0", dut.r_credit[2]); end
        n_cmp++; if (bank_push !== 4'b0100) begin n_fail++; $display("FAIL refill_push: got %b expected 0100", bank_push); end
        @(negedge clk);
        set_req(2, 1, 2, 7, 0, 0, 0);
        #1;
        n_cmp++; if (oc_grant !== 4'b0100) begin n_fail++; $display("FAIL poppush_grant: got %b expected 0100", oc_grant); end
        n_cmp++; if (dut.r_credit[2] !== 4'd1) begin n_fail++; $display("FAIL poppush_before: got %0d expected 1", dut.r_credit[2]); end
        @(negedge clk);
        clear_req();
        bank_pop = 4'b0000;
        #1;
        n_cmp++; if (dut.r_credit[2] !== 4'd1) begin n_fail++; $display("FAIL poppush_after: got %0d expected 1", dut.r_credit[2]); end
        n_cmp++; if (bank_push !== 4'b0100) begin n_fail++; $display("FAIL poppush_push: got %b expected 0100", bank_push); end
    endtask

    // Pop a full bank, then reset in the middle of a burst.
    task automatic test_credit_err();
        @(negedge clk);
        bank_pop = 4'b0010;
        #1;
        n_cmp++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b expected 0", credit_err); end
        @(negedge clk);
        bank_pop = 4'b0000;
        #1;
        n_cmp++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", credit_err); end
        n_cmp++; if (dut.r_credit[1] !== 4'd8) begin n_fail++; $display("FAIL err_sat: got %0d expected 8", dut.r_credit[1]); end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", credit_err); end
        // rr pointer is 3 after the last OC2 grant: burst grants OC3 then OC0.
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 1, i, i, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (oc_grant !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_grant: got %b expected 0000", oc_grant); end
        n_cmp++; if (bank_push !== 4'b0001) begin n_fail++; $display("FAIL burst_push: got %b expected 0001", bank_push); end
        @(negedge clk);
        rst = 1'b0;
        clear_req();
        #1;
        n_cmp++; if (bank_push !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_push: got %b expected 0000", bank_push); end
        n_cmp++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b expected 0", credit_err); end
        for (int b = 0; b < 4; b++) begin
            n_cmp++; if (dut.r_credit[b[1:0]] !== 4'd8) begin n_fail++; $display("FAIL rst_mid_credit%0d: got %0d expected 8", b, dut.r_credit[b[1:0]]); end
        end
    endtask

    initial begin
        bank_pop = '0;
        clear_req();
        test_reset();
        test_single();
        test_same();
        test_two_op();
        test_split();
        test_zero_cost();
        test_rotation();
        test_fill();
        test_credit_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
